// File: rtl/hack_uart_tx_if.sv
// CPU data-memory port as seen by the UART: split read/write addresses,
// write data/strobe, and the combinational read-back path.
interface hack_uart_tx_if;
  logic [15:0] addressR;
  logic [15:0] addressW;
  logic [15:0] dataW;
  logic        writeM;
  logic [15:0] dataR;
  logic        rsel;

  modport master (
    output addressR, addressW, dataW, writeM,
    input  dataR, rsel
  );

  modport slave (
    input  addressR, addressW, dataW, writeM,
    output dataR, rsel
  );
endinterface

// File: rtl/hack_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS registers on the Hack
// data-memory port, one-byte holding buffer in front of the shift register.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | line high, waiting for a buffered byte
//   S_START | start bit (tx=0) for CLKS_PER_BIT cycles
//   S_DATA  | 8 data bits, LSB first, shift right per bit
//   S_STOP  | stop bit (tx=1); reload from buffer or go idle
module hack_uart_tx #(
  parameter logic [15:0] BASE         = 16'h2002,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rstn,
  hack_uart_tx_if.slave bus,
  output logic         tx
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_START   = 2'd1;
  localparam logic [1:0]  S_DATA    = 2'd2;
  localparam logic [1:0]  S_STOP    = 2'd3;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] STAT_ADDR = BASE + 16'd1;

  logic [1:0]  state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  hold;
  logic        hold_valid;
  logic        ovr;

  logic bit_done;
  logic take;
  logic wr_data;
  logic wr_stat;
  logic accept;
  logic ready;
  logic busy;

  assign bit_done = (bit_cnt == BIT_LAST);
  assign take     = hold_valid && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
  assign wr_data  = bus.writeM && (bus.addressW == BASE);
  assign wr_stat  = bus.writeM && (bus.addressW == STAT_ADDR);
  // Only the IDLE transfer frees the slot for a same-edge write; a write
  // landing on the STOP reload edge is treated as an overrun.
  assign accept   = !hold_valid || (state == S_IDLE);
  assign ready    = !hold_valid;
  assign busy     = (state != S_IDLE);

  always_comb begin
    bus.dataR = 16'h0000;
    bus.rsel  = 1'b0;
    if (bus.addressR == BASE) begin
      bus.rsel  = 1'b1;
      bus.dataR = {8'h00, hold};
    end else if (bus.addressR == STAT_ADDR) begin
      bus.rsel  = 1'b1;
      bus.dataR = {13'h0000, ovr, busy, ready};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold       <= 8'h00;
      hold_valid <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      if (take) begin
        hold_valid <= 1'b0;
      end
      if (wr_data && accept) begin
        hold       <= bus.dataW[7:0];
        hold_valid <= 1'b1;
      end
      if (wr_stat && bus.dataW[2]) begin
        ovr <= 1'b0;
      end
      if (wr_data && !accept) begin
        ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      bit_cnt <= 16'h0000;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          bit_cnt <= 16'h0000;
          if (hold_valid) begin
            shift <= hold;
            state <= S_START;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_done) begin
            bit_cnt <= 16'h0000;
            bit_idx <= 3'd0;
            state   <= S_DATA;
            tx      <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            bit_cnt <= 16'h0000;
            shift   <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          if (bit_done) begin
            bit_cnt <= 16'h0000;
            if (hold_valid) begin
              shift <= hold;
              state <= S_START;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_uart_tx.sv
// Directed bench for hack_uart_tx: bytes written are queued as expected
// frames and a line monitor checks every tx cycle against the queue head.
module tb_hack_uart_tx;

  localparam int          CPB    = 4;
  localparam logic [15:0] A_DATA = 16'h2002;
  localparam logic [15:0] A_STAT = 16'h2003;

  logic clk = 1'b0;
  logic rstn;
  logic tx;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic [7:0] sb[$];
  int         starts[$];

  hack_uart_tx_if bus();

  hack_uart_tx #(.BASE(16'h2002), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    bus.addressR = a;
    #1;
    chk(tag, bus.dataR, exp);
  endtask

  // drive one write; it is sampled on the next rising edge
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addressW = a;
    bus.dataW    = d;
    bus.writeM   = 1'b1;
    @(negedge clk);
    bus.writeM   = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit expect_accept);
    if (expect_accept) sb.push_back(b);
    wr(A_DATA, {8'hEE, b});
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    bus.addressR = A_STAT;
    #1;
    while (bus.dataR[1] !== 1'b0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 16'(n < bound), 16'd1);
  endtask

  // line monitor: decode each frame cycle by cycle against the queue head
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_frame;
  always @(negedge clk) begin
    if (!rstn) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        starts.push_back(cyc);
        chk("frame_expected", 16'(sb.size() > 0), 16'd1);
        if (sb.size() > 0) mon_frame = {1'b1, sb.pop_front(), 1'b0};
        else               mon_frame = 10'h3FF;
      end
      if (mon_active) begin
        chk($sformatf("tx_bit%0d", mon_cnt / CPB), {15'h0, tx}, {15'h0, mon_frame[mon_cnt / CPB]});
        mon_cnt++;
        if (mon_cnt == 10 * CPB) mon_active = 1'b0;
      end
    end
  end

  initial begin
    rstn         = 1'b0;
    bus.addressR = 16'h0000;
    bus.addressW = 16'h0000;
    bus.dataW    = 16'h0000;
    bus.writeM   = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_tx", {15'h0, tx}, 16'h0001);
    chk_rd(A_STAT, 16'h0001, "rst_status");
    chk("rst_rsel", {15'h0, bus.rsel}, 16'h0001);
    chk_rd(16'h2004, 16'h0000, "unsel_dataR");
    chk("unsel_rsel", {15'h0, bus.rsel}, 16'h0000);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // single byte, exact frame timing
    wr_byte(8'h55, 1'b1);
    chk("sb_tx_before", {15'h0, tx}, 16'h0001);
    chk_rd(A_STAT, 16'h0000, "sb_status_e0");
    @(negedge clk);
    chk("sb_tx_fall", {15'h0, tx}, 16'h0000);
    chk_rd(A_STAT, 16'h0003, "sb_status_e1");
    repeat (39) @(negedge clk);
    chk_rd(A_STAT, 16'h0003, "sb_busy_last");
    @(negedge clk);
    chk_rd(A_STAT, 16'h0001, "sb_busy_fall");
    chk_rd(A_DATA, 16'h0055, "sb_data_rd");
    repeat (3) @(negedge clk);

    // back-to-back frames
    wr_byte(8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    wr_byte(8'h3C, 1'b1);
    chk_rd(A_STAT, 16'h0002, "b2b_buffered");
    repeat (34) @(negedge clk);
    chk_rd(A_STAT, 16'h0002, "b2b_stop_last");
    @(negedge clk);
    chk_rd(A_STAT, 16'h0003, "b2b_reload");
    chk("b2b_tx_start", {15'h0, tx}, 16'h0000);
    wait_idle(200);
    chk("b2b_gap", 16'(starts[$] - starts[$-1]), 16'(10 * CPB));
    repeat (3) @(negedge clk);

    // overrun and clear
    wr_byte(8'h11, 1'b1);
    repeat (2) @(negedge clk);
    wr_byte(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    wr_byte(8'h33, 1'b0);
    chk_rd(A_STAT, 16'h0006, "ovr_set");
    wr(A_STAT, 16'h0004);
    chk_rd(A_STAT, 16'h0002, "ovr_clear");
    wait_idle(200);
    repeat (3) @(negedge clk);

    // write colliding with STOP reload edge -> overrun
    wr_byte(8'h44, 1'b1);
    repeat (3) @(negedge clk);
    wr_byte(8'h55, 1'b1);
    repeat (36) @(negedge clk);
    wr_byte(8'h66, 1'b0);
    chk_rd(A_STAT, 16'h0007, "stop_collide_ovr");
    wr(A_STAT, 16'h0004);
    chk_rd(A_STAT, 16'h0003, "stop_collide_clr");
    wait_idle(200);
    chk_rd(A_DATA, 16'h0055, "stop_collide_hold");
    repeat (3) @(negedge clk);

    // write on the IDLE transfer edge -> accepted
    wr_byte(8'h77, 1'b1);
    wr_byte(8'h88, 1'b1);
    chk_rd(A_STAT, 16'h0002, "idle_collide_ok");
    wait_idle(200);
    chk_rd(A_DATA, 16'h0088, "idle_collide_hold");
    repeat (3) @(negedge clk);

    // reset during data bit 3
    wr_byte(8'h91, 1'b1);
    repeat (18) @(negedge clk);
    chk("mid_bit3_low", {15'h0, tx}, 16'h0000);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_tx", {15'h0, tx}, 16'h0001);
    chk_rd(A_STAT, 16'h0001, "mid_rst_status");
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    wr_byte(8'h5A, 1'b1);
    wait_idle(200);
    chk_rd(A_DATA, 16'h005A, "post_rst_data");
    repeat (2) @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
